// File: rtl/stopwatch_pkg.sv
// Shared types and digit limits for the stopwatch run/pause controller.
package stopwatch_pkg;

    typedef logic [3:0] digit_t;

    typedef enum logic [1:0] {
        PAUSED = 2'd0,
        RUN    = 2'd1,
        ADJUST = 2'd2
    } sw_state_e;

    localparam digit_t SEC_TENS_MAX = 4'd5;
    localparam digit_t DIGIT_MAX    = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// One mod-(MAX+1) BCD digit with enable, synchronous clear and carry-out.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter digit_t MAX = DIGIT_MAX
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   clr_i,
    input  logic   en_i,
    output digit_t digit_o,
    output logic   carry_o
);

    digit_t digit_q;
    digit_t digit_d;

    always_comb begin
        digit_d = digit_q;
        if (clr_i) begin
            digit_d = '0;
        end else if (en_i) begin
            digit_d = (digit_q == MAX) ? '0 : digit_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o = digit_q;
    assign carry_o = en_i & (digit_q == MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause FSM and chained BCD MM:SS counter for the stopwatch display.
// Define STOPWATCH_ADJ_EN to build the ADJUST state (adj/sel/tick_2hz).
module stopwatch_ctrl
    import stopwatch_pkg::*;
(
    input  logic   src_clk,
    input  logic   src_rst,
    input  logic   pause_pulse,
    input  logic   clr_pulse,
    input  logic   tick_1hz,
    input  logic   tick_2hz,
    input  logic   adj,
    input  logic   sel,
    output digit_t min_tens,
    output digit_t min_ones,
    output digit_t sec_tens,
    output digit_t sec_ones,
    output logic   running
);

    sw_state_e state_q;
    logic      running_q;

    logic run_tick;
    logic adj_active;
    logic adj_sec;
    logic adj_min;
    logic en_sec_ones, en_min_ones;
    logic c_sec_ones, c_sec_tens, c_min_ones, c_min_tens;

    assign run_tick = (state_q == RUN) & tick_1hz;

`ifdef STOPWATCH_ADJ_EN
    assign adj_active = (state_q == ADJUST);
    assign adj_sec    = adj_active & tick_2hz & sel;
    assign adj_min    = adj_active & tick_2hz & ~sel;
`else
    logic unused_adj_inputs;
    assign unused_adj_inputs = &{1'b0, adj, sel, tick_2hz};
    assign adj_active = 1'b0;
    assign adj_sec    = 1'b0;
    assign adj_min    = 1'b0;
`endif

    // Tick enables are derived from the pre-transition state, so a tick
    // arriving with a pause or adj edge is still counted in RUN.
    always_ff @(posedge src_clk) begin
        if (src_rst) begin
            state_q   <= PAUSED;
            running_q <= 1'b0;
        end
`ifdef STOPWATCH_ADJ_EN
        else if (adj) begin
            state_q   <= ADJUST;
            running_q <= 1'b0;
        end else if (state_q == ADJUST) begin
            state_q   <= PAUSED;
            running_q <= 1'b0;
        end
`endif
        else if (pause_pulse) begin
            if (state_q == RUN) begin
                state_q   <= PAUSED;
                running_q <= 1'b0;
            end else begin
                state_q   <= RUN;
                running_q <= 1'b1;
            end
        end
    end

    assign running = running_q;

    // Seconds-to-minutes carry is cut in ADJUST so seconds wrap on their own.
    assign en_sec_ones = run_tick | adj_sec;
    assign en_min_ones = (c_sec_tens & ~adj_active) | adj_min;

    bcd_digit #(.MAX(DIGIT_MAX)) u_sec_ones (
        .clk_i   (src_clk),
        .rst_i   (src_rst),
        .clr_i   (clr_pulse),
        .en_i    (en_sec_ones),
        .digit_o (sec_ones),
        .carry_o (c_sec_ones)
    );

    bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk_i   (src_clk),
        .rst_i   (src_rst),
        .clr_i   (clr_pulse),
        .en_i    (c_sec_ones),
        .digit_o (sec_tens),
        .carry_o (c_sec_tens)
    );

    bcd_digit #(.MAX(DIGIT_MAX)) u_min_ones (
        .clk_i   (src_clk),
        .rst_i   (src_rst),
        .clr_i   (clr_pulse),
        .en_i    (en_min_ones),
        .digit_o (min_ones),
        .carry_o (c_min_ones)
    );

    bcd_digit #(.MAX(DIGIT_MAX)) u_min_tens (
        .clk_i   (src_clk),
        .rst_i   (src_rst),
        .clr_i   (clr_pulse),
        .en_i    (c_min_ones),
        .digit_o (min_tens),
        .carry_o (c_min_tens)
    );

    logic unused_carry;
    assign unused_carry = c_min_tens;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed plus randomized bench for stopwatch_ctrl against a seconds-count model.
module tb_stopwatch_ctrl;

`ifdef STOPWATCH_ADJ_EN
    localparam bit ADJ_EN = 1'b1;
`else
    localparam bit ADJ_EN = 1'b0;
`endif

    logic       src_clk = 1'b0;
    logic       src_rst = 1'b0;
    logic       pause_pulse = 1'b0;
    logic       clr_pulse = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       tick_2hz = 1'b0;
    logic       adj = 1'b0;
    logic       sel = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Model: minutes 0..99, seconds 0..59, mode 0=paused 1=run 2=adjust
    int m_min  = 0;
    int m_sec  = 0;
    int m_mode = 0;

    stopwatch_ctrl dut (
        .src_clk     (src_clk),
        .src_rst     (src_rst),
        .pause_pulse (pause_pulse),
        .clr_pulse   (clr_pulse),
        .tick_1hz    (tick_1hz),
        .tick_2hz    (tick_2hz),
        .adj         (adj),
        .sel         (sel),
        .min_tens    (min_tens),
        .min_ones    (min_ones),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .running     (running)
    );

    always #5 src_clk = ~src_clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int tot;
        if (src_rst) begin
            m_min  = 0;
            m_sec  = 0;
            m_mode = 0;
        end else begin
            if (clr_pulse) begin
                m_min = 0;
                m_sec = 0;
            end else if (m_mode == 1 && tick_1hz) begin
                tot   = (m_min * 60 + m_sec + 1) % 6000;
                m_min = tot / 60;
                m_sec = tot % 60;
            end else if (m_mode == 2 && tick_2hz) begin
                if (sel) m_sec = (m_sec + 1) % 60;
                else     m_min = (m_min + 1) % 100;
            end
            if (ADJ_EN && adj)        m_mode = 2;
            else if (m_mode == 2)     m_mode = 0;
            else if (pause_pulse)     m_mode = (m_mode == 1) ? 0 : 1;
        end
    endtask

    task automatic cyc();
        @(posedge src_clk);
        model_step();
        #1;
        chk("min_tens", {4'd0, min_tens}, 8'(m_min / 10));
        chk("min_ones", {4'd0, min_ones}, 8'(m_min % 10));
        chk("sec_tens", {4'd0, sec_tens}, 8'(m_sec / 10));
        chk("sec_ones", {4'd0, sec_ones}, 8'(m_sec % 10));
        chk("running",  {7'd0, running},  {7'd0, (m_mode == 1)});
        src_rst     = 1'b0;
        pause_pulse = 1'b0;
        clr_pulse   = 1'b0;
        tick_1hz    = 1'b0;
        tick_2hz    = 1'b0;
    endtask

    task automatic ticks1(input int n);
        for (int i = 0; i < n; i++) begin
            tick_1hz = 1'b1;
            cyc();
        end
    endtask

    task automatic ticks2(input int n);
        for (int i = 0; i < n; i++) begin
            tick_2hz = 1'b1;
            cyc();
        end
    endtask

    task automatic chk_time(input string tag, input int mm, input int ss, input bit run);
        chk({tag, "_mt"}, {4'd0, min_tens}, 8'(mm / 10));
        chk({tag, "_mo"}, {4'd0, min_ones}, 8'(mm % 10));
        chk({tag, "_st"}, {4'd0, sec_tens}, 8'(ss / 10));
        chk({tag, "_so"}, {4'd0, sec_ones}, 8'(ss % 10));
        chk({tag, "_run"}, {7'd0, running}, {7'd0, run});
    endtask

    initial begin
        // Reset, with a pause pulse that must be ignored
        src_rst = 1'b1; pause_pulse = 1'b1; cyc();
        src_rst = 1'b1; cyc();
        chk_time("reset", 0, 0, 1'b0);

        pause_pulse = 1'b1; cyc();
        chk_time("start", 0, 0, 1'b1);
        ticks1(61);
        chk_time("t61", 1, 1, 1'b1);

        // Pause together with tick at 00:05
        clr_pulse = 1'b1; cyc();
        ticks1(5);
        pause_pulse = 1'b1; tick_1hz = 1'b1; cyc();
        chk_time("pause_tick", 0, 6, 1'b0);
        ticks1(3);
        chk_time("hold", 0, 6, 1'b0);

        // Pause with tick while paused: no increment, goes to RUN
        pause_pulse = 1'b1; tick_1hz = 1'b1; cyc();
        chk_time("resume_tick", 0, 6, 1'b1);

        // Clear with tick at 12:34
        clr_pulse = 1'b1; cyc();
        ticks1(754);
        chk_time("t1234", 12, 34, 1'b1);
        clr_pulse = 1'b1; tick_1hz = 1'b1; cyc();
        chk_time("clr_tick", 0, 0, 1'b1);

        // Reset mid-run at 07:42
        ticks1(462);
        chk_time("t0742", 7, 42, 1'b1);
        src_rst = 1'b1; pause_pulse = 1'b1; tick_1hz = 1'b1; clr_pulse = 1'b1; cyc();
        chk_time("rst_mid", 0, 0, 1'b0);

        // Full wrap 99:59 -> 00:00
        pause_pulse = 1'b1; cyc();
        ticks1(5999);
        chk_time("t9959", 99, 59, 1'b1);
        ticks1(1);
        chk_time("wrap", 0, 0, 1'b1);

        if (ADJ_EN) begin
            // adj rising with a tick in RUN: tick counted, then ADJUST
            adj = 1'b1; tick_1hz = 1'b1; cyc();
            chk_time("adj_enter", 0, 1, 1'b0);
            clr_pulse = 1'b1; cyc();
            sel = 1'b1;
            ticks2(58);
            chk_time("adj_s58", 0, 58, 1'b0);
            ticks2(3);
            chk_time("adj_swrap", 0, 1, 1'b0);
            sel = 1'b0;
            ticks2(99);
            chk_time("adj_m99", 99, 1, 1'b0);
            ticks2(1);
            chk_time("adj_mwrap", 0, 1, 1'b0);
            tick_1hz = 1'b1; pause_pulse = 1'b1; cyc();
            chk_time("adj_ign", 0, 1, 1'b0);
            adj = 1'b0; cyc();
            chk_time("adj_exit", 0, 1, 1'b0);
            pause_pulse = 1'b1; cyc();
            chk_time("adj_resume", 0, 1, 1'b1);
        end

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            src_rst     = ($urandom % 300) == 0;
            pause_pulse = ($urandom % 16) == 0;
            clr_pulse   = ($urandom % 80) == 0;
            tick_1hz    = ($urandom % 3) == 0;
            tick_2hz    = ($urandom % 4) == 0;
            if (($urandom % 40) == 0) adj = ~adj;
            if (($urandom % 8) == 0)  sel = ~sel;
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
